drive_assist_sched: RTL and testbench
=====================================

Name: drive_assist_sched

Overview:
- Computes the motor target current from rider inputs, calculating it on request over several cycles.
- All products go through one shared registered multiplier. A small FSM chooses the multiplier operands each cycle.
- Sits between the sensor/inertial front end, which issues `start` strobes, and the PID/brushless drive, which consumes `target_curr` when `vld` is high.
- Trades a fixed 4-cycle latency for a single multiplier instance.

Parameters:
- TORQUE_MIN, 12'h380: torque dead-band subtracted from `avg_torque`.
- CAD_THRESH, 1: cadence at or below this value gives zero assist.
- CAD_OFFSET, 32: added to cadence when cadence is above CAD_THRESH.
- INC_OFFSET, 256: added to the saturated incline.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a new target computation (one-cycle strobe).
- avg_torque  in  12  filtered pedal torque, unsigned.
- cadence  in  5  pedal cadence, unsigned.
- not_pedaling  in  1  rider not pedaling; forces zero assist.
- incline  in  13  signed incline.
- scale  in  3  assist level, 0..7.
- target_curr  out  12  computed target current; holds its value between updates.
- vld  out  1  one-cycle pulse; `target_curr` was updated this cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  one-cycle pulse; a start was dropped because a request was already pending.

Behaviour:
- Reset (async, rst_n low): `target_curr`=0, `vld`=0, `busy`=0, `overrun`=0, pend=0, FSM=IDLE, capture and product registers=0.
- Reset mid-computation aborts the computation; no `vld` is issued for it.
- FSM states: IDLE, MUL1, MUL2, MUL3, DONE.
- IDLE + start: capture all inputs on that edge, go to MUL1.
- MUL1: multiplier computes torque_pos*scale; p1 is registered on exit; go to MUL2.
- MUL2: multiplier computes cadence_factor*incline_lim; p2 is registered on exit; go to MUL3.
- MUL3: multiplier computes p1*p2; the registered result is forced to 0 if captured not_pedaling=1; go to DONE.
- DONE: saturate the result into `target_curr` on the exit edge; `vld` is high the following cycle.
- DONE exit: if start or pend, capture live inputs, clear pend, go to MUL1; otherwise go to IDLE.
- Latency: start sampled at edge k gives `target_curr`/`vld` updated at edge k+4.
- Back-to-back throughput: one result per 4 cycles.
- Start in MUL1–MUL3: set pend.
- Start in MUL1–MUL3 with pend already set: pulse `overrun` for one cycle; pend stays 1 (requests coalesce).
- Start in DONE: treated as the immediate next request, not as pend.
- A pending re-run samples inputs live at DONE exit, not at the time of the strobe.
- Captured operands are not affected by input changes after capture.
- Arithmetic, all in captured values:
  - incline_sat = incline clipped to [-512, 511] (10-bit signed).
  - incline_lim = incline_sat + INC_OFFSET, clipped to [0, 511] (9-bit).
  - cadence_factor = cadence > CAD_THRESH ? cadence + CAD_OFFSET : 0 (6-bit).
  - torque_pos = max(avg_torque − TORQUE_MIN, 0) (12-bit).
  - p1 ≤ 28665 and p2 ≤ 32193, each fits 15 bits.
  - Product is 30 bits, unsigned.
  - target_curr = product[29:27] != 0 ? 12'hFFF : product[26:15].
- Multiplier inputs are 16 bits, zero-extended; the result register is 32 bits; the top 2 bits are always 0 and are ignored.

Decomposition:
- Package drive_assist_pkg holds:
  - the state enum typedef (IDLE, MUL1, MUL2, MUL3, DONE);
  - the default constants TORQUE_MIN, CAD_OFFSET, INC_OFFSET;
  - the saturation limits SAT_POS=511 and SAT_NEG=-512.
- Sub-module shared_mult: 16x16 unsigned multiplier with a registered 32-bit output and an enable input. It shares clk/rst_n and is the only multiplier in the block.
- Operand muxing, pend and saturation stay in drive_assist_sched.

Test Plan:
- Nominal: avg_torque=0x800, scale=3, cadence=10, incline=0, not_pedaling=0, start at edge k → `target_curr`=0x46E with `vld` pulse at edge k+4; `busy` high for cycles k..k+3.
- Saturation: avg_torque=0xFFF, scale=7, cadence=31, incline=13'h0FFF → `target_curr`=0xFFF.
- Zero paths:
  - incline=-300 (13'h1ED4) with the nominal other inputs → 0.
  - cadence=1 → 0.
  - not_pedaling=1 → 0.
  - avg_torque=0x300 → 0.
  - Every case still pulses `vld` at k+4.
- Queueing:
  - start at k plus starts at k+1 and k+2 → one `overrun` pulse at k+2.
  - Results at k+4 and k+8 only; the second result uses inputs live at edge k+4.
- Back-to-back: start exactly in the DONE cycle (k+3) → `vld` at k+4 and k+8; no `overrun`; `busy` stays high continuously.
- Reset: rst_n low in MUL2 → all outputs 0 immediately; no `vld`; after release the nominal start again yields 0x46E.

Source files
------------

// File: rtl/drive_assist_pkg.sv
// ----------------------------------------------------------------------------
// drive_assist_pkg : shared types and default constants for drive_assist_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package drive_assist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    MUL2 = 3'd2,
    MUL3 = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic        [11:0] TORQUE_MIN_DEF = 12'h380;
  localparam logic        [5:0]  CAD_OFFSET_DEF = 6'd32;
  localparam logic signed [12:0] INC_OFFSET_DEF = 13'sd256;

  localparam logic signed [12:0] SAT_POS = 13'sd511;
  localparam logic signed [12:0] SAT_NEG = -13'sd512;

endpackage

`default_nettype wire

// File: rtl/drive_assist_sched_mult.sv
// ----------------------------------------------------------------------------
// shared_mult : 16x16 unsigned multiplier with enabled, registered 32-bit output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shared_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  logic [31:0] r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= {16'b0, i_a} * {16'b0, i_b};
    end
  end

  assign o_p = r_p;

endmodule

`default_nettype wire

// File: rtl/drive_assist_sched.sv
// ----------------------------------------------------------------------------
// drive_assist_sched : motor target current from rider inputs, 4-cycle schedule
// over one shared registered multiplier.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module drive_assist_sched
  import drive_assist_pkg::*;
#(
  parameter logic        [11:0] TORQUE_MIN = TORQUE_MIN_DEF,
  parameter logic        [4:0]  CAD_THRESH = 5'd1,
  parameter logic        [5:0]  CAD_OFFSET = CAD_OFFSET_DEF,
  parameter logic signed [12:0] INC_OFFSET = INC_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] avg_torque,
  input  logic [4:0]  cadence,
  input  logic        not_pedaling,
  input  logic [12:0] incline,
  input  logic [2:0]  scale,
  output logic [11:0] target_curr,
  output logic        vld,
  output logic        busy,
  output logic        overrun
);

  state_e             r_state;
  logic               r_pend;
  logic               r_vld;
  logic               r_overrun;
  logic [11:0]        r_target;

  logic [11:0]        r_torque;
  logic [4:0]         r_cad;
  logic signed [12:0] r_inc;
  logic [2:0]         r_scale;
  logic               r_np;
  logic [14:0]        r_p1;

  logic               w_cap;
  logic               w_in_mul;
  logic [11:0]        w_torque_pos;
  logic [5:0]         w_cad_factor;
  logic signed [12:0] w_inc_sat;
  logic signed [12:0] w_inc_sum;
  logic [8:0]         w_inc_lim;
  logic               w_mul_en;
  logic [15:0]        w_mul_a;
  logic [15:0]        w_mul_b;
  logic [31:0]        w_prod;
  logic [11:0]        w_sat;

  // A pending request re-samples the live inputs at DONE exit.
  assign w_cap    = ((r_state == IDLE) && start) ||
                    ((r_state == DONE) && (start || r_pend));
  assign w_in_mul = (r_state == MUL1) || (r_state == MUL2) || (r_state == MUL3);

  assign w_torque_pos = (r_torque > TORQUE_MIN) ? (r_torque - TORQUE_MIN) : 12'd0;
  assign w_cad_factor = (r_cad > CAD_THRESH) ? ({1'b0, r_cad} + CAD_OFFSET) : 6'd0;

  assign w_inc_sat = (r_inc > SAT_POS) ? SAT_POS :
                     (r_inc < SAT_NEG) ? SAT_NEG : r_inc;
  assign w_inc_sum = w_inc_sat + INC_OFFSET;
  assign w_inc_lim = (w_inc_sum < 13'sd0)   ? 9'd0   :
                     (w_inc_sum > SAT_POS)  ? 9'd511 : w_inc_sum[8:0];

  always_comb begin
    w_mul_en = 1'b0;
    w_mul_a  = '0;
    w_mul_b  = '0;
    case (r_state)
      MUL1: begin
        w_mul_en = 1'b1;
        w_mul_a  = {4'b0, w_torque_pos};
        w_mul_b  = {13'b0, r_scale};
      end
      MUL2: begin
        w_mul_en = 1'b1;
        w_mul_a  = {10'b0, w_cad_factor};
        w_mul_b  = {7'b0, w_inc_lim};
      end
      MUL3: begin
        w_mul_en = 1'b1;
        w_mul_a  = {1'b0, r_p1};
        w_mul_b  = {1'b0, w_prod[14:0]};
      end
      default: ;
    endcase
  end

  shared_mult u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_mul_en),
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .o_p   (w_prod)
  );

  assign w_sat = r_np                  ? 12'd0   :
                 (w_prod[31:27] != '0) ? 12'hFFF : w_prod[26:15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_torque <= '0;
      r_cad    <= '0;
      r_inc    <= '0;
      r_scale  <= '0;
      r_np     <= 1'b0;
    end else if (w_cap) begin
      r_torque <= avg_torque;
      r_cad    <= cadence;
      r_inc    <= incline;
      r_scale  <= scale;
      r_np     <= not_pedaling;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pend    <= 1'b0;
      r_vld     <= 1'b0;
      r_overrun <= 1'b0;
      r_target  <= '0;
      r_p1      <= '0;
    end else begin
      r_vld     <= 1'b0;
      r_overrun <= 1'b0;
      // Further starts while computing coalesce into a single pending request.
      if (w_in_mul && start) begin
        if (r_pend) r_overrun <= 1'b1;
        else        r_pend    <= 1'b1;
      end
      case (r_state)
        IDLE: if (start) r_state <= MUL1;
        MUL1: r_state <= MUL2;
        MUL2: begin
          r_p1    <= w_prod[14:0];
          r_state <= MUL3;
        end
        MUL3: r_state <= DONE;
        DONE: begin
          r_target <= w_sat;
          r_vld    <= 1'b1;
          if (start || r_pend) begin
            r_pend  <= 1'b0;
            r_state <= MUL1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign target_curr = r_target;
  assign vld         = r_vld;
  assign busy        = (r_state != IDLE);
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_drive_assist_sched.sv
// ----------------------------------------------------------------------------
// tb_drive_assist_sched : directed self-checking bench for drive_assist_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_drive_assist_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] avg_torque = '0;
  logic [4:0]  cadence = '0;
  logic        not_pedaling = 1'b0;
  logic [12:0] incline = '0;
  logic [2:0]  scale = '0;
  logic [11:0] target_curr;
  logic        vld;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  drive_assist_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .incline      (incline),
    .scale        (scale),
    .target_curr  (target_curr),
    .vld          (vld),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [11:0] t, input logic [2:0] s, input logic [4:0] c,
                        input logic [12:0] inc, input logic np);
    avg_torque   = t;
    scale        = s;
    cadence      = c;
    incline      = inc;
    not_pedaling = np;
  endtask

  task automatic set_nominal();
    set_in(12'h800, 3'd3, 5'd10, 13'h0000, 1'b0);
  endtask

  task automatic set_sat();
    set_in(12'hFFF, 3'd7, 5'd31, 13'h0FFF, 1'b0);
  endtask

  // One request from IDLE: start sampled at edge k, result expected after edge k+4.
  task automatic run_case(input string name, input logic [11:0] exp);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (vld !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s pipe k+%0d: vld=%b busy=%b, want vld=0 busy=1", name, j, vld, busy);
      end
      @(negedge clk);
    end
    checks++;
    if (vld !== 1'b1 || target_curr !== exp) begin
      errors++;
      $display("FAIL %s result: vld=%b target=%h, want vld=1 target=%h", name, vld, target_curr, exp);
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b overrun=%b, want 0 0", name, busy, overrun);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b0) begin
      errors++;
      $display("FAIL %s vld_pulse: vld=%b, want 0", name, vld);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (target_curr !== 12'h000 || vld !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: target=%h vld=%b busy=%b ovr=%b, want 000 0 0 0",
               target_curr, vld, busy, overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    set_nominal();
    run_case("nominal", 12'h46E);
  endtask

  task automatic test_saturation();
    set_sat();
    run_case("saturation", 12'hFFF);
  endtask

  task automatic test_zero_paths();
    set_in(12'h800, 3'd3, 5'd10, 13'h1ED4, 1'b0);
    run_case("zero_incline", 12'h000);
    set_in(12'h800, 3'd3, 5'd1, 13'h0000, 1'b0);
    run_case("zero_cadence", 12'h000);
    set_in(12'h800, 3'd3, 5'd10, 13'h0000, 1'b1);
    run_case("zero_not_pedaling", 12'h000);
    set_in(12'h300, 3'd3, 5'd10, 13'h0000, 1'b0);
    run_case("zero_torque", 12'h000);
  endtask

  task automatic test_queueing();
    int extra_vld;
    extra_vld = 0;
    set_nominal();
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL queue_no_overrun_k1: overrun=%b, want 0", overrun);
    end
    @(negedge clk); start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL queue_overrun_k2: overrun=%b, want 1", overrun);
    end
    // Changed after capture: first result must ignore these, second must use them.
    set_sat();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || vld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL queue_k3: ovr=%b vld=%b busy=%b, want 0 0 1", overrun, vld, busy);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b1 || target_curr !== 12'h46E || busy !== 1'b1) begin
      errors++;
      $display("FAIL queue_first: vld=%b target=%h busy=%b, want 1 46E 1", vld, target_curr, busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (vld !== 1'b0 || overrun !== 1'b0) extra_vld++;
    end
    checks++;
    if (extra_vld != 0) begin
      errors++;
      $display("FAIL queue_gap: stray vld/overrun cycles=%0d, want 0", extra_vld);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b1 || target_curr !== 12'hFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL queue_second: vld=%b target=%h busy=%b, want 1 FFF 0", vld, target_curr, busy);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL queue_end: vld=%b busy=%b, want 0 0", vld, busy);
    end
  endtask

  task automatic test_back_to_back();
    int busy_low;
    int ovr_seen;
    busy_low = 0;
    ovr_seen = 0;
    set_nominal();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (busy !== 1'b1) busy_low++;
      if (overrun !== 1'b0) ovr_seen++;
      @(negedge clk);
    end
    // Now in DONE (after edge k+3): this start is sampled at edge k+4.
    if (busy !== 1'b1) busy_low++;
    start = 1'b1;
    set_sat();
    @(negedge clk); start = 1'b0;
    checks++;
    if (vld !== 1'b1 || target_curr !== 12'h46E) begin
      errors++;
      $display("FAIL b2b_first: vld=%b target=%h, want 1 46E", vld, target_curr);
    end
    for (int j = 0; j < 4; j++) begin
      if (busy !== 1'b1) busy_low++;
      if (overrun !== 1'b0) ovr_seen++;
      @(negedge clk);
    end
    checks++;
    if (vld !== 1'b1 || target_curr !== 12'hFFF) begin
      errors++;
      $display("FAIL b2b_second: vld=%b target=%h, want 1 FFF", vld, target_curr);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL b2b_busy: busy low cycles=%0d, want 0", busy_low);
    end
    checks++;
    if (ovr_seen != 0) begin
      errors++;
      $display("FAIL b2b_overrun: overrun cycles=%0d, want 0", ovr_seen);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midcalc();
    int vld_seen;
    vld_seen = 0;
    set_nominal();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    // In MUL2; target_curr still holds the previous nonzero result.
    rst_n = 1'b0;
    #1;
    checks++;
    if (target_curr !== 12'h000 || vld !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: target=%h vld=%b busy=%b ovr=%b, want 000 0 0 0",
               target_curr, vld, busy, overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (vld !== 1'b0 || busy !== 1'b0) vld_seen++;
    end
    checks++;
    if (vld_seen != 0) begin
      errors++;
      $display("FAIL midreset_no_vld: active cycles=%0d, want 0", vld_seen);
    end
    set_nominal();
    run_case("after_reset", 12'h46E);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_zero_paths();
    test_queueing();
    test_back_to_back();
    test_reset_midcalc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
